uart_word_tx: RTL
=================

Name: uart_word_tx

Overview:
- Transmit side of the instruction-upload UART link.
- Accepts 32-bit words from on-chip logic (instruction/data memory dump, status readback) into a small word FIFO.
- Sends each word as eight UART 8N1 bytes, one nibble per byte, low nibble first: the same framing the host-to-board loader consumes.
- Sits between the memory readback logic and the board UART_RXD_OUT pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); minimum 2.
- FIFO_DEPTH, 16, word FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- word_in  input  32  word to transmit.
- word_valid  input  1  word_in valid this cycle.
- word_ready  output  1  FIFO can accept; transfer on rising edge with word_valid && word_ready.
- tx  output  1  UART serial out, idle high.
- tx_busy  output  1  high while FIFO non-empty or FSM not IDLE.
- words_sent  output  16  count of fully transmitted words, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (asserted, async):
  - tx=1, word_ready=1, tx_busy=0, words_sent=0.
  - FIFO emptied, FSM to IDLE, byte/bit/baud counters 0.
  - Takes effect immediately, including mid-bit; a partial frame is abandoned, not completed.
- word_ready = !fifo_full, registered from FIFO count.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, a pop that edge does not let a push land the same edge; word_ready rises the cycle after the pop.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If FIFO non-empty: pop the head word into the 32-bit shift word, set byte_idx=0, go to START.
  - tx=1 in IDLE.
- Byte formation: byte = {4'h0, word[byte_idx*4 +: 4]}. byte_idx 0..7, so nibble 0 (bits 3:0) goes first.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then load byte, bit_idx=0, go to DATA.
- DATA:
  - tx=byte[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - If byte_idx<7: byte_idx+1, go straight to START (no gap between bytes of one word).
  - If byte_idx==7: words_sent+1, go to IDLE.
- Latency:
  - A word accepted at edge N into an empty FIFO with FSM idle is popped at edge N+1.
  - tx falls at edge N+2.
- Timing:
  - Word frame = 80*CLKS_PER_BIT cycles.
  - Between consecutive words, tx stays high for the STOP period plus exactly 1 extra IDLE cycle.
- tx is driven from a flop, so no combinational glitches reach the pin.
- No data-dependent behaviour: 32'hFFFFFFFF (the loader's end marker) is transmitted like any other word.
- tx_busy falls in the first IDLE cycle where the FIFO is empty.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset: assert reset low, release -> tx=1, word_ready=1, tx_busy=0, words_sent=0. Nothing changes for 100 cycles without word_valid.
- Single word: push 32'h1234ABCD at edge N -> tx low from N+2; decoded bytes 0x0D,0x0C,0x0B,0x0A,0x04,0x03,0x02,0x01; each bit 4 cycles; no inter-byte gap. words_sent=1 and tx_busy=0 at N+2+320.
- Back-pressure: hold word_valid with words W0..W5 from edge 0 ->
  - W0..W4 accepted (W0 popped at edge 1).
  - word_ready=0 after edge 4.
  - W5 accepted only after W0 completes and W1 pops.
  - Output order W0..W5, words_sent=6.
- Back-to-back gap: two words queued -> exactly 4+1 high cycles between the last data bit of word 0 and the start bit of word 1.
- End marker: push 32'hFFFFFFFF -> eight 0x0F bytes, normal framing, words_sent increments.
- Reset mid-frame: assert reset during DATA of byte 3 with 2 words queued -> tx=1 immediately. After release: no start bit, tx_busy=0, words_sent=0, word_ready=1.

Source files
------------

// File: rtl/uart_word_tx.sv
// Word-to-UART transmitter: queues 32-bit words and sends each as eight 8N1 bytes,
// one nibble per byte, low nibble first (same framing as the host loader).
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        tx_busy,
  output logic [15:0] words_sent
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_countNext;
  logic               r_wordReady;
  logic [31:0]        r_shift;
  logic [7:0]         r_byte;
  logic [2:0]         r_byteIdx;
  logic [2:0]         r_bitIdx;
  logic [BAUD_W-1:0]  r_baudCnt;
  logic               r_tx;
  logic [15:0]        r_wordsSent;
  logic               w_push;
  logic               w_pop;
  logic               w_baudDone;

  assign w_push     = word_valid && r_wordReady;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_baudDone = (r_baudCnt == BAUD_LAST);

  assign word_ready = r_wordReady;
  assign tx         = r_tx;
  assign tx_busy    = (r_state != IDLE) || (r_count != '0);
  assign words_sent = r_wordsSent;

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= word_in;
  end

  // Ready is registered from the post-edge count, so a pop while full frees a slot one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_wordReady <= 1'b1;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count     <= w_countNext;
      r_wordReady <= (w_countNext != FIFO_FULL);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (r_count != '0) w_nextState = START;
      START: if (w_baudDone) w_nextState = DATA;
      DATA:  if (w_baudDone && (r_bitIdx == 3'd7)) w_nextState = STOP;
      STOP:  if (w_baudDone) w_nextState = (r_byteIdx == 3'd7) ? IDLE : START;
      default: w_nextState = IDLE;
    endcase
  end

  // tx is a flop driven from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_byte      <= '0;
      r_byteIdx   <= '0;
      r_bitIdx    <= '0;
      r_baudCnt   <= '0;
      r_tx        <= 1'b1;
      r_wordsSent <= '0;
    end else begin
      r_state <= w_nextState;

      if (r_state == IDLE || w_baudDone) r_baudCnt <= '0;
      else                               r_baudCnt <= r_baudCnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift   <= r_mem[r_rdPtr];
            r_byteIdx <= '0;
          end
        end
        START: begin
          if (w_baudDone) begin
            r_byte   <= {4'h0, r_shift[{r_byteIdx, 2'b00} +: 4]};
            r_bitIdx <= '0;
          end
        end
        DATA: begin
          if (w_baudDone) r_bitIdx <= r_bitIdx + 1'b1;
        end
        STOP: begin
          if (w_baudDone) begin
            if (r_byteIdx != 3'd7) r_byteIdx   <= r_byteIdx + 1'b1;
            else                   r_wordsSent <= r_wordsSent + 1'b1;
          end
        end
        default: ;
      endcase

      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_byte[r_bitIdx];
        default: r_tx <= 1'b1;
      endcase
    end
  end

endmodule
